// File: rtl/wb_rr_arbiter_nx1.sv
// Round-robin N:1 Wishbone arbiter: the grant is held for the owner's whole CYC,
// and a watchdog aborts stalled transfers with ERR to the owner.
//
// state | meaning
// IDLE  | no owner, scanning m_CYC from last+1
// BUSY  | owner connected to the slave port
// ABORT | one-cycle ERR to the owner after a watchdog expiry
// DRAIN | slave isolated, waiting for the owner to drop CYC
module wb_rr_arbiter_nx1 #(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int N_MASTERS      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]       m_ADR,
  input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]       m_DAT_W,
  input  logic [N_MASTERS*(WB_DATA_WIDTH/8)-1:0]   m_SEL,
  input  logic [N_MASTERS*3-1:0]                   m_CTI,
  input  logic [N_MASTERS*2-1:0]                   m_BTE,
  input  logic [N_MASTERS-1:0]                     m_CYC,
  input  logic [N_MASTERS-1:0]                     m_STB,
  input  logic [N_MASTERS-1:0]                     m_WE,
  output logic [WB_DATA_WIDTH-1:0]                 m_DAT_R,
  output logic [N_MASTERS-1:0]                     m_ACK,
  output logic [N_MASTERS-1:0]                     m_ERR,
  output logic [WB_ADDR_WIDTH-1:0]                 s_ADR,
  output logic [WB_DATA_WIDTH-1:0]                 s_DAT_W,
  output logic [WB_DATA_WIDTH/8-1:0]               s_SEL,
  output logic [2:0]                               s_CTI,
  output logic [1:0]                               s_BTE,
  output logic                                     s_CYC,
  output logic                                     s_STB,
  output logic                                     s_WE,
  input  logic [WB_DATA_WIDTH-1:0]                 s_DAT_R,
  input  logic                                     s_ACK,
  input  logic                                     s_ERR,
  output logic [N_MASTERS-1:0]                     gnt,
  output logic                                     timeout_evt
);

  localparam int SW = WB_DATA_WIDTH / 8;
  localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int WW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ABORT, ST_DRAIN} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        last_q, last_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [WW-1:0]        wd_q, wd_d;
  logic [PW-1:0]        cand;
  logic                 found;
  logic                 busy, own_cyc, own_stb, own_we;

  logic [WB_ADDR_WIDTH-1:0] adr_a  [N_MASTERS];
  logic [WB_DATA_WIDTH-1:0] datw_a [N_MASTERS];
  logic [SW-1:0]            sel_a  [N_MASTERS];
  logic [2:0]               cti_a  [N_MASTERS];
  logic [1:0]               bte_a  [N_MASTERS];

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_slice
    assign adr_a[i]  = m_ADR[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
    assign datw_a[i] = m_DAT_W[i*WB_DATA_WIDTH +: WB_DATA_WIDTH];
    assign sel_a[i]  = m_SEL[i*SW +: SW];
    assign cti_a[i]  = m_CTI[i*3 +: 3];
    assign bte_a[i]  = m_BTE[i*2 +: 2];
  end

  // last_q doubles as the owner index whenever state_q is not IDLE
  assign own_cyc = m_CYC[last_q];
  assign own_stb = m_STB[last_q];
  assign own_we  = m_WE[last_q];
  assign busy    = (state_q == ST_BUSY);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      last_q  <= PW'(N_MASTERS - 1);
      gnt_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    wd_d    = wd_q;
    cand    = last_q;
    found   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        for (int k = 0; k < N_MASTERS; k++) begin
          cand = (cand == PW'(N_MASTERS - 1)) ? '0 : cand + 1'b1;
          if (!found && m_CYC[cand]) begin
            found       = 1'b1;
            last_d      = cand;
            gnt_d       = '0;
            gnt_d[cand] = 1'b1;
            wd_d        = '0;
            state_d     = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else if (s_ACK || s_ERR || !own_stb) begin
          wd_d = '0;
        end else begin
          // a response in the final stall cycle takes the branch above, so ACK beats the abort
          if (TIMEOUT_CYCLES > 0 && wd_q == WW'(TIMEOUT_CYCLES - 1)) state_d = ST_ABORT;
          if (wd_q != WW'(TIMEOUT_CYCLES)) wd_d = wd_q + 1'b1;
        end
      end
      ST_ABORT: state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign s_ADR       = adr_a[last_q];
  assign s_DAT_W     = datw_a[last_q];
  assign s_SEL       = sel_a[last_q];
  assign s_CTI       = cti_a[last_q];
  assign s_BTE       = bte_a[last_q];
  assign s_CYC       = busy & own_cyc;
  assign s_STB       = busy & own_stb;
  assign s_WE        = busy & own_we;
  assign m_DAT_R     = s_DAT_R;
  assign m_ACK       = (busy && s_ACK) ? gnt_q : '0;
  assign m_ERR       = ((busy && s_ERR) || state_q == ST_ABORT) ? gnt_q : '0;
  assign timeout_evt = (state_q == ST_ABORT);
  assign gnt         = gnt_q;

endmodule

// File: tb/tb_wb_rr_arbiter_nx1.sv
// Bench for wb_rr_arbiter_nx1: directed scenarios plus random masters/slave,
// all outputs compared each cycle against an owner/pointer reference model.
module tb_wb_rr_arbiter_nx1;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 8;

  logic clk = 1'b0;
  logic rstn;
  logic [N*AW-1:0]     m_ADR;
  logic [N*DW-1:0]     m_DAT_W;
  logic [N*(DW/8)-1:0] m_SEL;
  logic [N*3-1:0]      m_CTI;
  logic [N*2-1:0]      m_BTE;
  logic [N-1:0]        cyc_v, stb_v, we_v;
  logic [DW-1:0]       m_DAT_R;
  logic [N-1:0]        m_ACK, m_ERR, gnt;
  logic [AW-1:0]       s_ADR;
  logic [DW-1:0]       s_DAT_W;
  logic [DW/8-1:0]     s_SEL;
  logic [2:0]          s_CTI;
  logic [1:0]          s_BTE;
  logic                s_CYC, s_STB, s_WE;
  logic [DW-1:0]       s_DAT_R;
  logic                s_ACK, s_ERR;
  logic                timeout_evt;

  logic [AW-1:0]   adr_a  [N];
  logic [DW-1:0]   datw_a [N];
  logic [DW/8-1:0] sel_a  [N];
  logic [2:0]      cti_a  [N];
  logic [1:0]      bte_a  [N];

  always #5 clk = ~clk;

  always_comb begin
    m_ADR = '0; m_DAT_W = '0; m_SEL = '0; m_CTI = '0; m_BTE = '0;
    for (int i = 0; i < N; i++) begin
      m_ADR[i*AW +: AW]           = adr_a[i];
      m_DAT_W[i*DW +: DW]         = datw_a[i];
      m_SEL[i*(DW/8) +: (DW/8)]   = sel_a[i];
      m_CTI[i*3 +: 3]             = cti_a[i];
      m_BTE[i*2 +: 2]             = bte_a[i];
    end
  end

  wb_rr_arbiter_nx1 #(
    .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .N_MASTERS(N), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rstn(rstn),
    .m_ADR(m_ADR), .m_DAT_W(m_DAT_W), .m_SEL(m_SEL), .m_CTI(m_CTI), .m_BTE(m_BTE),
    .m_CYC(cyc_v), .m_STB(stb_v), .m_WE(we_v),
    .m_DAT_R(m_DAT_R), .m_ACK(m_ACK), .m_ERR(m_ERR),
    .s_ADR(s_ADR), .s_DAT_W(s_DAT_W), .s_SEL(s_SEL), .s_CTI(s_CTI), .s_BTE(s_BTE),
    .s_CYC(s_CYC), .s_STB(s_STB), .s_WE(s_WE),
    .s_DAT_R(s_DAT_R), .s_ACK(s_ACK), .s_ERR(s_ERR),
    .gnt(gnt), .timeout_evt(timeout_evt)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // reference model: who owns the port, who was granted last, stall run length
  int   owner = -1;
  int   last  = N - 1;
  int   stall = 0;
  bit   aborting = 0;
  bit   draining = 0;
  bit   dead_slave = 0;
  logic [N-1:0] prev_ack = '0;
  logic [N-1:0] prev_err = '0;
  int   rem [N];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit model_busy();
    return owner >= 0 && !aborting && !draining;
  endfunction

  // compare this cycle's outputs, then advance the model across the next clk edge
  task automatic step();
    logic [N-1:0] eg, eack, eerr;
    logic ecyc, estb, ewe;
    #1;
    if (!rstn) begin
      owner = -1; last = N - 1; stall = 0; aborting = 0; draining = 0;
      prev_ack = '0; prev_err = '0;
      check_eq("rst_gnt", 64'(gnt), 64'(0));
      check_eq("rst_ctl", 64'({s_CYC, s_STB, s_WE}), 64'(0));
      check_eq("rst_resp", 64'({m_ACK, m_ERR, timeout_evt}), 64'(0));
      return;
    end
    eg = '0; ecyc = 0; estb = 0; ewe = 0;
    if (owner >= 0) eg[owner] = 1'b1;
    if (model_busy()) begin
      ecyc = cyc_v[owner]; estb = stb_v[owner]; ewe = we_v[owner];
    end
    eack = (model_busy() && s_ACK) ? eg : '0;
    eerr = ((model_busy() && s_ERR) || aborting) ? eg : '0;
    check_eq("gnt", 64'(gnt), 64'(eg));
    check_eq("s_ctl", 64'({s_CYC, s_STB, s_WE}), 64'({ecyc, estb, ewe}));
    check_eq("m_ack", 64'(m_ACK), 64'(eack));
    check_eq("m_err", 64'(m_ERR), 64'(eerr));
    check_eq("timeout_evt", 64'(timeout_evt), 64'(aborting));
    check_eq("m_dat_r", 64'(m_DAT_R), 64'(s_DAT_R));
    if (ecyc) begin
      check_eq("s_adr", 64'(s_ADR), 64'(adr_a[owner]));
      check_eq("s_dat_w", 64'(s_DAT_W), 64'(datw_a[owner]));
      check_eq("s_attr", 64'({s_SEL, s_CTI, s_BTE}), 64'({sel_a[owner], cti_a[owner], bte_a[owner]}));
    end
    prev_ack = eack;
    prev_err = eerr;
    if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        automatic int c = (last + k) % N;
        if (cyc_v[c]) begin
          owner = c; last = c; stall = 0;
          dead_slave = ($urandom_range(0, 5) == 0);
          break;
        end
      end
    end else if (aborting) begin
      aborting = 0; draining = 1;
    end else if (draining) begin
      if (!cyc_v[owner]) begin owner = -1; draining = 0; end
    end else if (!cyc_v[owner]) begin
      owner = -1;
    end else if (stb_v[owner] && !s_ACK && !s_ERR) begin
      stall++;
      if (stall == T) aborting = 1;
    end else begin
      stall = 0;
    end
  endtask

  task automatic new_beat(input int i);
    adr_a[i]  = $urandom;
    datw_a[i] = $urandom;
    sel_a[i]  = 4'($urandom);
    cti_a[i]  = 3'($urandom);
    bte_a[i]  = 2'($urandom);
    we_v[i]   = 1'($urandom);
  endtask

  task automatic idle_all();
    cyc_v = '0; stb_v = '0; we_v = '0;
    s_ACK = 0; s_ERR = 0;
  endtask

  task automatic gen_random();
    for (int i = 0; i < N; i++) begin
      if (cyc_v[i]) begin
        if (prev_err[i]) begin
          cyc_v[i] = 0; stb_v[i] = 0;
        end else if (prev_ack[i]) begin
          rem[i]--;
          if (rem[i] == 0) begin cyc_v[i] = 0; stb_v[i] = 0; end
          else new_beat(i);
        end else if (owner != i && $urandom_range(0, 39) == 0) begin
          cyc_v[i] = 0; stb_v[i] = 0;
        end
        if (cyc_v[i]) stb_v[i] = (owner != i) || ($urandom_range(0, 15) != 0);
      end else if ($urandom_range(0, 3) == 0) begin
        cyc_v[i] = 1; stb_v[i] = 1; rem[i] = $urandom_range(1, 4);
        new_beat(i);
      end
    end
    s_ACK = 0; s_ERR = 0; s_DAT_R = $urandom;
    if (model_busy()) begin
      if (cyc_v[owner] && stb_v[owner] && !dead_slave) begin
        automatic int r = $urandom_range(0, 19);
        s_ACK = (r < 9);
        s_ERR = (r == 9);
      end
    end else begin
      s_ACK = ($urandom_range(0, 4) == 0);
      s_ERR = ($urandom_range(0, 9) == 0);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; adr_a[i] = '0; datw_a[i] = '0; sel_a[i] = '0; cti_a[i] = '0; bte_a[i] = '0;
    end
    idle_all();
    s_DAT_R = '0;
    rstn = 1;
    #1 rstn = 0;
    @(negedge clk); step();
    @(negedge clk); rstn = 1; step();

    // single request from master 2, slave answers on the third granted cycle
    @(negedge clk); cyc_v[2] = 1; stb_v[2] = 1; we_v[2] = 0; adr_a[2] = 32'h100; step();
    @(negedge clk); step();
    check_eq("single_gnt", 64'(gnt), 64'(4'b0100));
    check_eq("single_adr", 64'(s_ADR), 64'(32'h100));
    @(negedge clk); step();
    @(negedge clk); s_ACK = 1; s_DAT_R = 32'hCAFE0001; step();
    check_eq("single_ack", 64'({m_ACK, m_DAT_R}), 64'({4'b0100, 32'hCAFE0001}));
    @(negedge clk); s_ACK = 0; cyc_v[2] = 0; stb_v[2] = 0; step();
    @(negedge clk); step();

    // watchdog abort on master 3, late ACK ignored, then master 0 is served
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c == 0) begin cyc_v[3] = 1; stb_v[3] = 1; we_v[3] = 1; end
      if (c == 2) begin cyc_v[0] = 1; stb_v[0] = 1; we_v[0] = 0; end
      if (c == 12) begin cyc_v[3] = 0; stb_v[3] = 0; end
      if (c == 16) begin cyc_v[0] = 0; stb_v[0] = 0; end
      s_ACK = (c >= 9 && c <= 11) || c == 15;
      step();
      if (c == 9) check_eq("tmo_pulse", 64'({timeout_evt, m_ERR, s_CYC}), 64'({1'b1, 4'b1000, 1'b0}));
      if (c == 10) check_eq("tmo_late_ack", 64'(m_ACK), 64'(0));
      if (c == 14) check_eq("tmo_next_gnt", 64'(gnt), 64'(4'b0001));
    end

    // ACK on the final stall cycle wins over the watchdog
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c == 0) begin cyc_v[1] = 1; stb_v[1] = 1; end
      if (c == 9) begin cyc_v[1] = 0; stb_v[1] = 0; end
      s_ACK = (c == 8);
      step();
      if (c == 8) check_eq("limit_ack", 64'(m_ACK), 64'(4'b0010));
      if (c == 9) check_eq("limit_no_tmo", 64'(timeout_evt), 64'(0));
    end

    // locked 4-beat burst by master 1 while master 0 waits
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin cyc_v[1] = 1; stb_v[1] = 1; cti_a[1] = 3'b010; end
      if (c == 1) begin cyc_v[0] = 1; stb_v[0] = 1; end
      if (c == 6) begin cyc_v[1] = 0; stb_v[1] = 0; end
      if (c == 9) begin cyc_v[0] = 0; stb_v[0] = 0; end
      s_ACK = (c >= 2 && c <= 5) || c == 8;
      step();
      if (c == 5) check_eq("burst_owner", 64'(gnt), 64'(4'b0010));
      if (c == 8) check_eq("burst_next", 64'(gnt), 64'(4'b0001));
    end

    @(negedge clk); idle_all(); step();
    @(negedge clk); step();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); gen_random(); step();
    end

    // reset while master 2 is mid-write
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); idle_all(); step();
    end
    @(negedge clk); cyc_v[2] = 1; stb_v[2] = 1; we_v[2] = 1; step();
    @(negedge clk); step();
    @(negedge clk); s_ACK = 1;
    #2 rstn = 0;
    #1;
    check_eq("arst_ctl", 64'({s_CYC, s_STB, gnt, m_ACK}), 64'(0));
    step();
    @(negedge clk); rstn = 1; s_ACK = 0; cyc_v = '1; stb_v = '1; step();
    @(negedge clk); step();
    check_eq("arst_first_gnt", 64'(gnt), 64'(4'b0001));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/wb_rr_arbiter_nx1.md
Name: wb_rr_arbiter_nx1

Overview:
Shares one Wishbone slave port among N_MASTERS Wishbone masters using round-robin arbitration. Grant is held for the owner's entire CYC assertion, so bursts and read-modify-write sequences stay atomic. A watchdog aborts stalled transfers and returns ERR to the owner. Sits in front of shared peripherals or memories, or in front of one slave port of the interconnect.

Parameters:
WB_ADDR_WIDTH, 32, address width
WB_DATA_WIDTH, 32, data width; SEL width = WB_DATA_WIDTH/8
N_MASTERS, 4, number of requesters (>=1)
TIMEOUT_CYCLES, 256, max stall cycles with owner STB high and no ACK/ERR; 0 disables watchdog

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
m_ADR  in  N_MASTERS*WB_ADDR_WIDTH  master i address at slice i
m_DAT_W  in  N_MASTERS*WB_DATA_WIDTH  master write data
m_SEL  in  N_MASTERS*(WB_DATA_WIDTH/8)  byte selects
m_CTI  in  N_MASTERS*3  cycle type
m_BTE  in  N_MASTERS*2  burst type
m_CYC  in  N_MASTERS  cycle request
m_STB  in  N_MASTERS  strobe
m_WE  in  N_MASTERS  write enable
m_DAT_R  out  WB_DATA_WIDTH  read data, broadcast to all masters
m_ACK  out  N_MASTERS  ack, owner only
m_ERR  out  N_MASTERS  error, owner only
s_ADR/s_DAT_W/s_SEL/s_CTI/s_BTE  out  per field  muxed owner request
s_CYC, s_STB, s_WE  out  1  muxed owner controls
s_DAT_R  in  WB_DATA_WIDTH  slave read data
s_ACK, s_ERR  in  1  slave response
gnt  out  N_MASTERS  one-hot current owner (status)
timeout_evt  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, rstn low): state=IDLE; gnt=0; last pointer=N_MASTERS-1, so master 0 has top priority first; watchdog=0; s_CYC=s_STB=s_WE=0; m_ACK=m_ERR=0; timeout_evt=0. Other s_* fields are don't-care while s_CYC=0. Reset during a transfer drops s_CYC immediately.
- States:
  - IDLE: no owner. On each clk, scan m_CYC starting at last+1 and wrap modulo N_MASTERS. The first requester found becomes owner: gnt and last update, next state BUSY. If there is no request, stay in IDLE.
  - BUSY: the slave request fields and CYC/STB/WE follow owner inputs combinationally from the registered gnt. s_ACK and s_ERR route to the owner's bit only. Non-owners see ACK=ERR=0 and stall. s_DAT_R is passed through to m_DAT_R unchanged.
  - ABORT: lasts exactly one cycle. s_CYC=s_STB=0, m_ERR[owner]=1, timeout_evt=1. Next state is DRAIN.
  - DRAIN: slave is isolated (s_CYC=0). Owner ACK=ERR=0. Stay until m_CYC[owner]=0, then IDLE with gnt=0.
- Transitions out of BUSY:
  - If m_CYC[owner]=0 at the clk edge: go to IDLE, gnt=0. At least one dead cycle (s_CYC=0) separates consecutive owners.
  - If the watchdog reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES>0): go to ABORT.
- Latency: m_CYC rises at edge t, gnt is set at t+1, and s_CYC/s_STB are visible during cycle t+1. Response path (ACK/ERR/DAT_R) has zero added latency.
- Watchdog:
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - Clears on entry to BUSY, on s_ACK or s_ERR, and whenever owner STB=0.
  - Increments each BUSY cycle with owner STB=1 and no response. Saturates (no wrap).
  - If s_ACK arrives in the same cycle the count would hit the limit, the ACK wins: it is delivered, the count clears, and there is no abort.
- Late s_ACK/s_ERR in ABORT, DRAIN or IDLE is ignored and never reaches any master.
- A master that drops CYC while waiting, without ever being granted, is simply skipped.
- Fairness: with all masters requesting continuously, grant order is 0,1,…,N-1,0… Each master waits at most N_MASTERS-1 tenures.
- N_MASTERS=1: the pointer is fixed at 0 and the behaviour is otherwise identical.
- Error passthrough: s_ERR in BUSY goes to the owner. It does not change state; the owner decides whether to drop CYC.

Test Plan:
- Single request: m_CYC[2]=STB=1, WE=0, ADR=0x100 at t; slave ACKs at t+3 with DAT_R=0xCAFE0001 -> gnt=4'b0100 at t+1, s_ADR=0x100, m_ACK[2]=1 with m_DAT_R=0xCAFE0001 at t+3, m_ACK[0,1,3]=0.
- Round-robin: all four m_CYC held high, each with one single-beat access -> gnt order 0,1,2,3,0 with one s_CYC=0 cycle between tenures; no master ACKed twice before the others.
- Locked burst: master 1 holds CYC for a 4-beat CTI=010 burst while master 0 requests -> all 4 ACKs go to master 1, master 0 granted only after master 1 drops CYC.
- Timeout: TIMEOUT_CYCLES=8, slave never ACKs master 3 -> after 8 stall cycles, one cycle of m_ERR[3]=1 and timeout_evt=1 with s_CYC=0; a late s_ACK is ignored; after m_CYC[3] falls, master 0 is granted.
- ACK at limit: slave ACKs on the 8th stall cycle -> normal ACK delivered, timeout_evt stays 0.
- Mid-transfer reset: rstn low during a BUSY write -> s_CYC, s_STB, gnt and m_ACK go to 0 asynchronously; after release, master 0 wins first arbitration.
